// File: rtl/ahb_mtx_decoder_param.sv
// rtl/ahb_mtx_decoder_param.sv - AHB matrix input-stage address decoder with remap window and default slave
module ahb_mtx_decoder_param #(
    parameter int                      NUM_PORTS   = 4,
    parameter int                      DATA_W      = 32,
    parameter int                      RUSER_W     = 4,
    parameter logic [32*NUM_PORTS-1:0] REGION_BASE = {32'hE0000000, 32'h40000000, 32'h20000000, 32'h00000000},
    parameter logic [32*NUM_PORTS-1:0] REGION_MASK = {32'hF0000000, 32'hE0000000, 32'hE0000000, 32'hFFFC0000},
    parameter logic [31:0]             REMAP_BASE  = 32'h00040000,
    parameter logic [31:0]             REMAP_MASK  = 32'hFFFC0000,
    parameter int                      REMAP_PORT  = 3,
    parameter int                      ERRCNT_W    = 8
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic                         remapping_dec,
    input  logic                         HREADYS,
    input  logic                         sel_dec,
    input  logic [21:0]                  decode_addr_dec,
    input  logic [1:0]                   trans_dec,
    input  logic [NUM_PORTS-1:0]         active_dec_in,
    input  logic [NUM_PORTS-1:0]         readyout_dec,
    input  logic [2*NUM_PORTS-1:0]       resp_dec,
    input  logic [DATA_W*NUM_PORTS-1:0]  rdata_dec,
    input  logic [RUSER_W*NUM_PORTS-1:0] ruser_dec,
    output logic [NUM_PORTS-1:0]         sel_out,
    output logic                         active_dec,
    output logic                         HREADYOUTS,
    output logic [1:0]                   HRESPS,
    output logic [DATA_W-1:0]            HRDATAS,
    output logic [RUSER_W-1:0]           HRUSERS,
    output logic [ERRCNT_W-1:0]          err_count,
    output logic [21:0]                  err_addr
);

    // Port index wide enough to also encode the default slave (index NUM_PORTS)
    localparam int            PW     = $clog2(NUM_PORTS + 1);
    localparam logic [PW-1:0] DS_IDX = PW'(NUM_PORTS);

    typedef enum logic [1:0] {
        DS_OK   = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

    logic [PW-1:0]       data_port_q, data_port_d;
    logic [PW-1:0]       addr_port;
    logic [PW-1:0]       match_port;
    logic                match_found;
    logic                remap_hit;
    ds_state_t           ds_state_q, ds_state_d;
    logic                ds_ready_q, ds_ready_d;
    logic [1:0]          ds_resp_q, ds_resp_d;
    logic                ds_accept;
    logic                err_inc;
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;
    logic [21:0]         err_addr_q, err_addr_d;

    // Region match (lowest index wins), remap override, and IDLE hold on the data-phase port
    always_comb begin
        match_port  = DS_IDX;
        match_found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!match_found &&
                ((decode_addr_dec & REGION_MASK[32*i+10 +: 22]) ==
                 (REGION_BASE[32*i+10 +: 22] & REGION_MASK[32*i+10 +: 22]))) begin
                match_port  = PW'(i);
                match_found = 1'b1;
            end
        end
        remap_hit = remapping_dec &&
                    ((decode_addr_dec & REMAP_MASK[31:10]) == (REMAP_BASE[31:10] & REMAP_MASK[31:10]));
        if (trans_dec == 2'b00) begin
            addr_port = data_port_q;
        end else if (remap_hit) begin
            addr_port = PW'(REMAP_PORT);
        end else begin
            addr_port = match_port;
        end
    end

    // One-hot output select and active of the addressed port; the default slave is always active
    always_comb begin
        sel_out    = '0;
        active_dec = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr_port == PW'(i)) begin
                sel_out[i] = sel_dec;
                active_dec = active_dec_in[i];
            end
        end
    end

    // Data-phase port follows the address phase whenever the input stage is ready
    always_comb begin
        data_port_d = HREADYS ? addr_port : data_port_q;
    end

    // Default slave next state: two-cycle ERROR for every accepted unmapped NONSEQ/SEQ
    always_comb begin
        ds_accept  = sel_dec && (addr_port == DS_IDX) && HREADYS && trans_dec[1];
        ds_state_d = ds_state_q;
        case (ds_state_q)
            DS_OK:   if (ds_accept) ds_state_d = DS_ERR1;
            DS_ERR1: ds_state_d = DS_ERR2;
            DS_ERR2: begin
                if (ds_accept)    ds_state_d = DS_ERR1;
                else if (HREADYS) ds_state_d = DS_OK;
            end
            default: ds_state_d = DS_OK;
        endcase
        ds_ready_d = (ds_state_d != DS_ERR1);
        ds_resp_d  = (ds_state_d == DS_OK) ? 2'b00 : 2'b01;
    end

    // Saturating unmapped-access counter and last unmapped address, both updated on entry to DS_ERR1
    always_comb begin
        err_inc     = (ds_state_d == DS_ERR1) && (ds_state_q != DS_ERR1);
        err_count_d = err_count_q;
        err_addr_d  = err_addr_q;
        if (err_inc) begin
            err_addr_d = decode_addr_dec;
            if (err_count_q != {ERRCNT_W{1'b1}}) begin
                err_count_d = err_count_q + ERRCNT_W'(1);
            end
        end
    end

    // State registers, including the registered default-slave ready/response
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            data_port_q <= DS_IDX;
            ds_state_q  <= DS_OK;
            ds_ready_q  <= 1'b1;
            ds_resp_q   <= 2'b00;
            err_count_q <= '0;
            err_addr_q  <= '0;
        end else begin
            data_port_q <= data_port_d;
            ds_state_q  <= ds_state_d;
            ds_ready_q  <= ds_ready_d;
            ds_resp_q   <= ds_resp_d;
            err_count_q <= err_count_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // Zero-latency data-phase return mux; the default slave returns zero data and user bits
    always_comb begin
        HREADYOUTS = ds_ready_q;
        HRESPS     = ds_resp_q;
        HRDATAS    = '0;
        HRUSERS    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (data_port_q == PW'(i)) begin
                HREADYOUTS = readyout_dec[i];
                HRESPS     = resp_dec[2*i +: 2];
                HRDATAS    = rdata_dec[DATA_W*i +: DATA_W];
                HRUSERS    = ruser_dec[RUSER_W*i +: RUSER_W];
            end
        end
    end

    assign err_count = err_count_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_ahb_mtx_decoder_param.sv
// tb/tb_ahb_mtx_decoder_param.sv - directed self-checking bench for ahb_mtx_decoder_param
module tb_ahb_mtx_decoder_param;

    logic         HCLK = 1'b0;
    logic         HRESET;
    logic         remapping_dec;
    logic         HREADYS;
    logic         sel_dec;
    logic [21:0]  decode_addr_dec;
    logic [1:0]   trans_dec;
    logic [3:0]   active_dec_in;
    logic [3:0]   readyout_dec;
    logic [7:0]   resp_dec;
    logic [127:0] rdata_dec;
    logic [15:0]  ruser_dec;
    logic [3:0]   sel_out;
    logic         active_dec;
    logic         HREADYOUTS;
    logic [1:0]   HRESPS;
    logic [31:0]  HRDATAS;
    logic [3:0]   HRUSERS;
    logic [7:0]   err_count;
    logic [21:0]  err_addr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 HCLK = ~HCLK;

    ahb_mtx_decoder_param dut (
        .HCLK            (HCLK),
        .HRESET          (HRESET),
        .remapping_dec   (remapping_dec),
        .HREADYS         (HREADYS),
        .sel_dec         (sel_dec),
        .decode_addr_dec (decode_addr_dec),
        .trans_dec       (trans_dec),
        .active_dec_in   (active_dec_in),
        .readyout_dec    (readyout_dec),
        .resp_dec        (resp_dec),
        .rdata_dec       (rdata_dec),
        .ruser_dec       (ruser_dec),
        .sel_out         (sel_out),
        .active_dec      (active_dec),
        .HREADYOUTS      (HREADYOUTS),
        .HRESPS          (HRESPS),
        .HRDATAS         (HRDATAS),
        .HRUSERS         (HRUSERS),
        .err_count       (err_count),
        .err_addr        (err_addr)
    );

    function automatic logic [21:0] a22(input logic [31:0] a);
        return a[31:10];
    endfunction

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic s, input logic [1:0] t, input logic [31:0] a, input logic rdy);
        sel_dec         = s;
        trans_dec       = t;
        decode_addr_dec = a22(a);
        HREADYS         = rdy;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 1'b1);
        step();
        step();
        HRESET = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_resp: got ready=%b resp=%b, want 1/00", HREADYOUTS, HRESPS);
        end
        n_checks++;
        if (HRDATAS !== 32'h0 || HRUSERS !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_data: got rdata=%h ruser=%h, want 0/0", HRDATAS, HRUSERS);
        end
        n_checks++;
        if (err_count !== 8'd0 || err_addr !== 22'h0) begin
            n_fail++;
            $display("FAIL reset_err: got cnt=%0d addr=%h, want 0/0", err_count, err_addr);
        end
        drive(1'b1, 2'b10, 32'h40000000, 1'b0);
        #1;
        n_checks++;
        if (sel_out !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_comb_sel: got %b want 0100", sel_out);
        end
    endtask

    task automatic test_decode();
        readyout_dec = 4'b1101;
        drive(1'b1, 2'b10, 32'h20000100, 1'b1);
        #1;
        n_checks++;
        if (sel_out !== 4'b0010 || active_dec !== 1'b1) begin
            n_fail++;
            $display("FAIL decode_sel: got sel=%b act=%b, want 0010/1", sel_out, active_dec);
        end
        step();
        drive(1'b0, 2'b00, 32'h0, 1'b1);
        #1;
        n_checks++;
        if (HREADYOUTS !== 1'b0 || HRDATAS !== 32'hBBBB0001 || HRUSERS !== 4'h2) begin
            n_fail++;
            $display("FAIL decode_data: got ready=%b rdata=%h ruser=%h, want 0/bbbb0001/2",
                     HREADYOUTS, HRDATAS, HRUSERS);
        end
        readyout_dec = 4'b1111;
        #1;
    endtask

    task automatic test_remap();
        remapping_dec = 1'b0;
        drive(1'b1, 2'b10, 32'h00000000, 1'b0);
        #1;
        n_checks++;
        if (sel_out !== 4'b0001) begin
            n_fail++;
            $display("FAIL remap_port0: got %b want 0001", sel_out);
        end
        drive(1'b1, 2'b10, 32'h00040000, 1'b0);
        #1;
        n_checks++;
        if (sel_out !== 4'b0000 || active_dec !== 1'b1) begin
            n_fail++;
            $display("FAIL remap_off: got sel=%b act=%b want 0000/1", sel_out, active_dec);
        end
        remapping_dec = 1'b1;
        #1;
        n_checks++;
        if (sel_out !== 4'b1000 || active_dec !== 1'b0) begin
            n_fail++;
            $display("FAIL remap_on: got sel=%b act=%b want 1000/0", sel_out, active_dec);
        end
        remapping_dec = 1'b0;
        #1;
    endtask

    task automatic test_unmapped();
        do_reset();
        drive(1'b1, 2'b10, 32'h60000000, 1'b1);
        #1;
        n_checks++;
        if (sel_out !== 4'b0000 || active_dec !== 1'b1) begin
            n_fail++;
            $display("FAIL unmapped_sel: got sel=%b act=%b want 0000/1", sel_out, active_dec);
        end
        step();
        drive(1'b0, 2'b00, 32'h0, 1'b0);
        #1;
        n_checks++;
        if (HREADYOUTS !== 1'b0 || HRESPS !== 2'b01 || HRDATAS !== 32'h0) begin
            n_fail++;
            $display("FAIL unmapped_err1: got ready=%b resp=%b rdata=%h want 0/01/0",
                     HREADYOUTS, HRESPS, HRDATAS);
        end
        n_checks++;
        if (err_count !== 8'd1 || err_addr !== 22'h180000) begin
            n_fail++;
            $display("FAIL unmapped_cnt: got cnt=%0d addr=%h want 1/180000", err_count, err_addr);
        end
        step();
        n_checks++;
        if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b01) begin
            n_fail++;
            $display("FAIL unmapped_err2: got ready=%b resp=%b want 1/01", HREADYOUTS, HRESPS);
        end
        HREADYS = 1'b1;
        step();
        n_checks++;
        if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b00) begin
            n_fail++;
            $display("FAIL unmapped_ok: got ready=%b resp=%b want 1/00", HREADYOUTS, HRESPS);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, (i == 0) ? 2'b10 : 2'b11, 32'h60000000 + (i << 10), 1'b1);
            step();
            if (i == 1) begin
                n_checks++;
                if (HREADYOUTS !== 1'b0 || HRESPS !== 2'b01 || err_count !== 8'd2) begin
                    n_fail++;
                    $display("FAIL b2b_no_gap: got ready=%b resp=%b cnt=%0d want 0/01/2",
                             HREADYOUTS, HRESPS, err_count);
                end
            end
            HREADYS = 1'b0;
            step();
            if (i == 0) begin
                n_checks++;
                if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b01) begin
                    n_fail++;
                    $display("FAIL b2b_err2: got ready=%b resp=%b want 1/01", HREADYOUTS, HRESPS);
                end
            end
            if (i == 9) begin
                n_checks++;
                if (err_count !== 8'd10) begin
                    n_fail++;
                    $display("FAIL b2b_cnt10: got %0d want 10", err_count);
                end
            end
        end
        n_checks++;
        if (err_count !== 8'd255 || err_addr !== 22'h18012B) begin
            n_fail++;
            $display("FAIL b2b_saturate: got cnt=%0d addr=%h want 255/18012b", err_count, err_addr);
        end
        drive(1'b0, 2'b00, 32'h0, 1'b1);
        step();
        n_checks++;
        if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b00 || err_count !== 8'd255) begin
            n_fail++;
            $display("FAIL b2b_recover: got ready=%b resp=%b cnt=%0d want 1/00/255",
                     HREADYOUTS, HRESPS, err_count);
        end
    endtask

    task automatic test_idle_hold();
        drive(1'b1, 2'b10, 32'h40000000, 1'b1);
        step();
        readyout_dec = 4'b1011;
        drive(1'b1, 2'b00, 32'h20000000, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (sel_out !== 4'b0100 || HREADYOUTS !== 1'b0 || HRDATAS !== 32'hCCCC0002) begin
                n_fail++;
                $display("FAIL idle_hold_%0d: got sel=%b ready=%b rdata=%h want 0100/0/cccc0002",
                         c, sel_out, HREADYOUTS, HRDATAS);
            end
            step();
        end
        readyout_dec = 4'b1111;
        #1;
        n_checks++;
        if (HREADYOUTS !== 1'b1 || HRUSERS !== 4'h3) begin
            n_fail++;
            $display("FAIL idle_release: got ready=%b ruser=%h want 1/3", HREADYOUTS, HRUSERS);
        end
    endtask

    task automatic test_reset_mid_error();
        drive(1'b1, 2'b10, 32'h70000000, 1'b1);
        step();
        n_checks++;
        if (HREADYOUTS !== 1'b0 || HRESPS !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_err_enter: got ready=%b resp=%b want 0/01", HREADYOUTS, HRESPS);
        end
        HRESET = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 1'b0);
        step();
        HRESET = 1'b0;
        #1;
        n_checks++;
        if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b00 || err_count !== 8'd0 || err_addr !== 22'h0) begin
            n_fail++;
            $display("FAIL rst_err_drop: got ready=%b resp=%b cnt=%0d addr=%h want 1/00/0/0",
                     HREADYOUTS, HRESPS, err_count, err_addr);
        end
    endtask

    initial begin
        HRESET        = 1'b1;
        remapping_dec = 1'b0;
        active_dec_in = 4'b0010;
        readyout_dec  = 4'b1111;
        resp_dec      = 8'h00;
        rdata_dec     = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        ruser_dec     = {4'h4, 4'h3, 4'h2, 4'h1};
        drive(1'b0, 2'b00, 32'h0, 1'b1);
        test_reset();
        test_decode();
        test_remap();
        test_unmapped();
        test_back_to_back();
        test_idle_hold();
        test_reset_mid_error();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
